// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC sequencer: FSM state, binary-angle
// constants and the quadrant-fold range test.
package cordic_pkg;

  localparam int unsigned CW = 16;

  localparam logic [CW-1:0] ANG_P90 = 16'h4000;
  localparam logic [CW-1:0] ANG_N90 = 16'hC000;
  localparam logic [CW-1:0] ANG_PI  = 16'h8000;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StIter,
    StDone
  } cordic_state_e;

  // True when the signed binary angle lies outside [-90deg, +90deg].
  function automatic logic ang_needs_fold(input logic [CW-1:0] ang);
    return ($signed(ang) > $signed(ANG_P90)) || ($signed(ang) < $signed(ANG_N90));
  endfunction

endpackage

// File: rtl/sat_neg16.sv
// Saturating 16-bit two's-complement negate; -0x8000 clamps to 0x7FFF.
// Used by cordic16_seq only when CORDIC_QUAD_FOLD_EN is defined.
module sat_neg16
  import cordic_pkg::*;
(
  input  logic [CW-1:0] a,
  output logic [CW-1:0] y
);

  always_comb begin
    if (a == ANG_PI) begin
      y = 16'h7FFF;
    end else begin
      y = ~a + 16'd1;
    end
  end

endmodule

// File: rtl/cordic16_seq.sv
// Control sequencer around the iterative CORDIC datapath: request handshake,
// load/addr stepping and held result registers. Optional CORDIC_QUAD_FOLD_EN
// folds mode-0 angles beyond +/-90deg into range and negates the results.
module cordic16_seq
  import cordic_pkg::*;
#(
  parameter int unsigned ITERS = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_angle,
  input  logic          in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_sin,
  output logic [CW-1:0] out_cos,
  output logic          out_mode,
  output logic [CW-1:0] endangle,
  output logic          load,
  output logic [3:0]    addr,
  output logic          modeSel,
  input  logic [CW-1:0] cor_sin,
  input  logic [CW-1:0] cor_cos,
  output logic          busy
);

  localparam logic [3:0] LastAddr = 4'(ITERS - 1);

  cordic_state_e state_q, state_d;

  logic [CW-1:0] endangle_q, endangle_d;
  logic          mode_q, mode_d;
  logic          load_q, load_d;
  logic [3:0]    addr_q, addr_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] out_sin_q, out_sin_d;
  logic [CW-1:0] out_cos_q, out_cos_d;
  logic [CW-1:0] res_sin, res_cos;
  logic [CW-1:0] req_angle;
  logic          req_fold;

  logic accept;
  logic capture;

  assign accept  = (state_q == StIdle) && in_valid;
  assign capture = (state_q == StIter) && (state_d == StDone);

`ifdef CORDIC_QUAD_FOLD_EN
  logic          fold_q, fold_d;
  logic [CW-1:0] neg_sin, neg_cos;

  sat_neg16 u_neg_sin (
    .a (cor_sin),
    .y (neg_sin)
  );

  sat_neg16 u_neg_cos (
    .a (cor_cos),
    .y (neg_cos)
  );

  assign req_fold  = !in_mode && ang_needs_fold(in_angle);
  assign req_angle = req_fold ? (in_angle + ANG_PI) : in_angle;
  assign res_sin   = fold_q ? neg_sin : cor_sin;
  assign res_cos   = fold_q ? neg_cos : cor_cos;

  always_comb begin
    fold_d = fold_q;
    if (accept) begin
      fold_d = req_fold;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fold_q <= 1'b0;
    end else begin
      fold_q <= fold_d;
    end
  end
`else
  assign req_fold  = 1'b0;
  assign req_angle = in_angle;
  assign res_sin   = cor_sin;
  assign res_cos   = cor_cos;
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = StLoad;
      StLoad: state_d = StIter;
      StIter: if (addr_q == LastAddr) state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs are derived from the upcoming state so they align with it.
  always_comb begin
    endangle_d  = endangle_q;
    mode_d      = mode_q;
    out_sin_d   = out_sin_q;
    out_cos_d   = out_cos_q;
    load_d      = (state_d == StLoad);
    busy_d      = (state_d != StIdle);
    out_valid_d = (state_d == StDone);
    addr_d      = '0;
    if ((state_q == StIter) && (state_d == StIter)) begin
      addr_d = addr_q + 4'd1;
    end
    if (accept) begin
      endangle_d = req_angle;
      mode_d     = in_mode;
    end
    if (capture) begin
      out_sin_d = res_sin;
      out_cos_d = res_cos;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      endangle_q  <= '0;
      mode_q      <= 1'b0;
      load_q      <= 1'b0;
      addr_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_sin_q   <= '0;
      out_cos_q   <= '0;
    end else begin
      endangle_q  <= endangle_d;
      mode_q      <= mode_d;
      load_q      <= load_d;
      addr_q      <= addr_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      out_sin_q   <= out_sin_d;
      out_cos_q   <= out_cos_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign endangle  = endangle_q;
  assign modeSel   = mode_q;
  assign out_mode  = mode_q;
  assign load      = load_q;
  assign addr      = addr_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sin   = out_sin_q;
  assign out_cos   = out_cos_q;

endmodule

// File: tb/tb_cordic16_seq.sv
// Directed bench for cordic16_seq; the datapath stand-in presents the model
// result only while addr is 15, so a mistimed capture shows up as 0xDEAD.
module tb_cordic16_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_angle = 16'h0;
  logic        in_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sin, out_cos;
  logic        out_mode;
  logic [15:0] endangle;
  logic        load;
  logic [3:0]  addr;
  logic        modeSel;
  logic [15:0] cor_sin, cor_cos;
  logic        busy;

  logic [15:0] m_sin = 16'h0;
  logic [15:0] m_cos = 16'h0;

  int n_pass  = 0;
  int n_total = 0;

  assign cor_sin = (addr == 4'd15) ? m_sin : 16'hDEAD;
  assign cor_cos = (addr == 4'd15) ? m_cos : 16'hDEAD;

  cordic16_seq #(.ITERS(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_angle  (in_angle),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sin   (out_sin),
    .out_cos   (out_cos),
    .out_mode  (out_mode),
    .endangle  (endangle),
    .load      (load),
    .addr      (addr),
    .modeSel   (modeSel),
    .cor_sin   (cor_sin),
    .cor_cos   (cor_cos),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One full operation from IDLE; out_ready is pulsed once the result is held.
  task automatic run_op(input string tag, input logic [15:0] ang, input logic md,
                        input logic [15:0] msin, input logic [15:0] mcos,
                        input logic [15:0] exp_ang, input logic [15:0] exp_sin,
                        input logic [15:0] exp_cos);
    int waited;
    m_sin    = msin;
    m_cos    = mcos;
    in_angle = ang;
    in_mode  = md;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, "_endangle"}, 32'(endangle), 32'(exp_ang));
    check({tag, "_modesel"}, 32'(modeSel), 32'(md));
    waited = 0;
    while (!out_valid && waited < 40) begin
      step();
      waited++;
    end
    check({tag, "_latency"}, 32'(waited), 32'd17);
    check({tag, "_sin"}, 32'(out_sin), 32'(exp_sin));
    check({tag, "_cos"}, 32'(out_cos), 32'(exp_cos));
    check({tag, "_outmode"}, 32'(out_mode), 32'(md));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_idle"}, 32'({in_ready, out_valid}), 32'b10);
  endtask

  initial begin
    int n;
    int ov_cycles;
    logic found;

    // Reset state
    step();
    check("rst_outs", 32'({load, out_valid, busy, modeSel, out_mode}), 32'd0);
    check("rst_addr_ang", 32'({addr, endangle}), 32'd0);
    reset = 1'b0;
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic operation: angle 0x2000, mode 0
    m_sin    = 16'h16A1;
    m_cos    = 16'h3B21;
    in_angle = 16'h2000;
    in_mode  = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("e0_load", 32'({load, addr, busy, in_ready}), 32'({1'b1, 4'd0, 1'b1, 1'b0}));
    check("e0_endangle", 32'(endangle), 32'h2000);
    for (int k = 0; k < 16; k++) begin
      step();
      check($sformatf("iter_addr%0d", k), 32'({load, addr, out_valid}),
            32'({1'b0, 4'(k), 1'b0}));
    end
    step();
    check("e17_valid", 32'({out_valid, addr, load, busy}), 32'({1'b1, 4'd0, 1'b0, 1'b1}));
    check("e17_sin", 32'(out_sin), 32'h16A1);
    check("e17_cos", 32'(out_cos), 32'h3B21);

    // Backpressure with an ignored request
    in_valid = 1'b1;
    in_angle = 16'h1234;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("bp_hold%0d", k), 32'({out_valid, in_ready, out_sin}),
            32'({1'b1, 1'b0, 16'h16A1}));
      check($sformatf("bp_ang%0d", k), 32'(endangle), 32'h2000);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_release", 32'({out_valid, in_ready, busy}), 32'b010);
    check("bp_kept", 32'({out_sin, out_cos}), 32'h16A13B21);

`ifdef CORDIC_QUAD_FOLD_EN
    run_op("fold6000", 16'h6000, 1'b0, 16'h2D41, 16'h2D41, 16'hE000, 16'hD2BF, 16'hD2BF);
    run_op("foldsat", 16'hA000, 1'b0, 16'h1000, 16'h8000, 16'h2000, 16'hF000, 16'h7FFF);
    run_op("mode1", 16'h6000, 1'b1, 16'h2D41, 16'h2D41, 16'h6000, 16'h2D41, 16'h2D41);
`else
    run_op("pass6000", 16'h6000, 1'b0, 16'h2D41, 16'h2D41, 16'h6000, 16'h2D41, 16'h2D41);
    run_op("nosat", 16'hA000, 1'b0, 16'h1000, 16'h8000, 16'hA000, 16'h1000, 16'h8000);
    run_op("mode1", 16'h6000, 1'b1, 16'h2D41, 16'h2D41, 16'h6000, 16'h2D41, 16'h2D41);
`endif

    // Reset in the middle of ITER
    in_angle = 16'h3000;
    in_mode  = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (addr == 4'd7 && !load) found = 1'b1;
    end
    check("reach_addr7", 32'(found), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_ctl", 32'({load, addr, out_valid, busy}), 32'd0);
    check("midrst_regs", 32'({endangle, modeSel, out_mode}), 32'd0);
    check("midrst_res", 32'({out_sin, out_cos}), 32'd0);
    step();
    reset = 1'b0;
    step();
    check("postrst_ready", 32'({in_ready, busy}), 32'b10);
    run_op("fresh", 16'h1000, 1'b0, 16'h0C7C, 16'h3EC5, 16'h1000, 16'h0C7C, 16'h3EC5);

    // Back-to-back with out_ready tied high
    m_sin     = 16'h2000;
    m_cos     = 16'h376D;
    out_ready = 1'b1;
    in_angle  = 16'h1555;
    in_mode   = 1'b0;
    in_valid  = 1'b1;
    step();
    check("b2b_first_load", 32'(load), 32'd1);
    n = 0;
    ov_cycles = 0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      n++;
      if (out_valid) ov_cycles++;
      if (in_ready) found = 1'b1;
    end
    check("b2b_spacing", 32'(n + 1), 32'd19);
    check("b2b_valid_once", 32'(ov_cycles), 32'd1);
    check("b2b_res", 32'({out_sin, out_cos}), 32'h2000376D);
    in_angle = 16'h0AAA;
    step();
    in_valid = 1'b0;
    check("b2b_second_load", 32'({load, endangle}), 32'({1'b1, 16'h0AAA}));
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cordic16_seq.md
# cordic16_seq

Sequencer wrapped around the 16-iteration CORDIC datapath. It accepts angle requests through a valid/ready handshake and drives the datapath's `endangle`, `load`, `addr` and `modeSel` inputs. It steps the iteration address once per clock, then captures the datapath's `sin`/`cos` results into held output registers with their own valid/ready handshake. It sits directly upstream and downstream of the CORDIC core: the only producer of its control inputs and the only consumer of its results.

## Interface
Parameters:
- `ITERS`, default 16: iterations per operation; `addr` counts 0..ITERS-1; must be ≤16.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  sequencer can accept a request.
- `in_angle`  in  16  signed binary angle; 0x4000 = +90°, 0xC000 = -90°.
- `in_mode`  in  1  datapath mode, forwarded to `modeSel`.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer takes result.
- `out_sin`, `out_cos`  out  16 each  captured results, signed Q1.14.
- `out_mode`  out  1  mode of the captured result.
- `endangle`  out  16  to datapath target angle.
- `load`  out  1  to datapath initialize strobe.
- `addr`  out  4  to datapath iteration index / ROM address.
- `modeSel`  out  1  to datapath mode select.
- `cor_sin`, `cor_cos`  in  16 each  from datapath results.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- The FSM has four states: IDLE, LOAD, ITER, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, register the angle into `endangle` and `in_mode` into `modeSel`/`out_mode`, then go to LOAD.
- LOAD:
  - `load`=1 and `addr`=0 for exactly one cycle, then go to ITER.
- ITER:
  - `load`=0; `addr` increments each cycle starting at 0.
  - In the cycle with `addr`=ITERS-1, the next edge captures `cor_sin`/`cor_cos` into `out_sin`/`out_cos` and goes to DONE.
- DONE:
  - `out_valid`=1; outputs held stable.
  - On `out_ready`, go to IDLE and clear `out_valid`. The result registers keep their values.
- `endangle` and `modeSel` are stable from the LOAD state until the sequencer returns to IDLE.
- `in_ready`=0 in LOAD, ITER and DONE. Requests offered then are ignored, not queued.
- `addr` stays 0 outside ITER.
- Async reset at any time, including mid-ITER:
  - State goes to IDLE.
  - `endangle`, `addr`, `out_sin`, `out_cos` are cleared to 0.
  - `load`, `modeSel`, `out_mode`, `out_valid`, `busy` are cleared to 0.
  - `in_ready`=1 from the first cycle after reset deasserts.
  - An in-flight operation is discarded.

## Timing
- Accept edge = E0. LOAD occupies E0→E1.
- `addr`=k occupies edge E(k+1)→E(k+2).
- Capture at edge E(ITERS+1); `out_valid` rises after E17 for ITERS=16.
- Minimum request-to-request spacing is ITERS+3 edges: out_ready is sampled on the first DONE cycle, and IDLE lasts one cycle.
- If `out_ready` is already high when DONE is entered, `out_valid` is high for exactly one cycle.
- All outputs are registered. There is no combinational path from `in_valid`/`out_ready` to any output except the state-derived `in_ready`.

## Configuration
- `CORDIC_QUAD_FOLD_EN` defined:
  - In mode 0 only, an `in_angle` with |angle| > 0x4000 is folded by adding 0x8000, modulo 2^16.
  - A fold flag is stored.
  - At capture, both results are negated. Negating 0x8000 saturates to 0x7FFF.
  - Mode 1 is never folded.
- `CORDIC_QUAD_FOLD_EN` undefined:
  - `in_angle` passes through unchanged and results are never negated.
  - Angles outside ±0x4000 give undefined results.

## Structure
- Shared package `cordic_pkg` holds:
  - the FSM state enum;
  - the angle constants `ANG_P90`=0x4000 and `ANG_N90`=0xC000;
  - `ANG_PI`=0x8000;
  - the width constant `CW`=16.
- One natural sub-module is `sat_neg16`, a saturating 16-bit negate. It is instantiated twice and exists only when `CORDIC_QUAD_FOLD_EN` is defined.

## Test plan
- Angle 0x2000, mode 0 → `endangle`=0x2000; `load` high exactly 1 cycle; `addr` 0..15 once each; `out_valid` after E17; outputs equal the model's `cor_sin`/`cor_cos`.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → outputs stable, `in_ready`=0, a new `in_valid` is ignored; `out_ready`=1 → IDLE next cycle.
- Fold enabled, angle 0x6000, model returns 0x2D41/0x2D41 → `endangle`=0xE000; `out_sin`=`out_cos`=0xD2BF.
- Fold enabled, model `cor_cos`=0x8000 on a folded request → `out_cos`=0x7FFF.
- Reset asserted while `addr`=7 → in the same cycle `load`/`addr`/`out_valid`/`busy`=0; after release `in_ready`=1 and a fresh request completes normally.
- Back-to-back requests with `out_ready` tied high → second accept exactly 19 edges after first; mode 1 with fold enabled leaves angle 0x6000 unfolded.
